// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU-to-UART bridge.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_FLAG,
        TX_ADDR,
        TX_DATA,
        RX_DATA,
        RESP
    } state_t;

    localparam logic [7:0] DEF_FLAG_LOAD  = 8'h01;
    localparam logic [7:0] DEF_FLAG_STORE = 8'h02;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lsu_byte_shifter.sv
// Byte-wide shift register: parallel load, shift left one byte with a new LSB byte.
// The MSB byte is the next byte out; shifting in from the LSB assembles received data.
module lsu_byte_shifter #(
    parameter int WIDTH_BYTES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [8*WIDTH_BYTES-1:0]   load_data,
    input  logic                       shift,
    input  logic [7:0]                 shift_in,
    output logic [8*WIDTH_BYTES-1:0]   data
);

    localparam int W = 8 * WIDTH_BYTES;

    logic [W-1:0] data_next;

    always_comb begin
        data_next = data;
        if (load)
            data_next = load_data;
        else if (shift)
            data_next = (data << 8) | W'(shift_in);
    end

    always_ff @(posedge clk) begin
        if (reset)
            data <= '0;
        else
            data <= data_next;
    end

endmodule

// File: rtl/lsu_uart_bridge.sv
// Converts one core load/store request into a UART byte frame (flag, address, data)
// and returns a one-cycle response, with a per-byte receive timeout for loads.
module lsu_uart_bridge
    import lsu_pkg::*;
#(
    parameter int         ADDR_BYTES     = 1,
    parameter int         DATA_BYTES     = 2,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter logic [7:0] FLAG_LOAD      = DEF_FLAG_LOAD,
    parameter logic [7:0] FLAG_STORE     = DEF_FLAG_STORE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_store,
    input  logic [8*ADDR_BYTES-1:0] req_addr,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data
);

    localparam int AW  = 8 * ADDR_BYTES;
    localparam int DW  = 8 * DATA_BYTES;
    localparam int BCW = $clog2(max2(ADDR_BYTES, DATA_BYTES)) + 1;
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTES - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BYTES - 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state_q, state_d;
    logic            op_q;
    logic [7:0]      flag_q;
    logic            tx_wait_q;
    logic [7:0]      hold_q;
    logic [BCW-1:0]  bcnt_q;
    logic [TW-1:0]   tcnt_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;

    logic [AW-1:0]   addr_word;
    logic [DW-1:0]   wdat_word;
    logic [DW-1:0]   rx_word;

    logic accept, is_tx, byte_done, rx_take, timeout_hit, rx_clr;

    lsu_byte_shifter #(.WIDTH_BYTES(ADDR_BYTES)) u_addr (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (req_addr),
        .shift     (state_q == TX_ADDR && byte_done),
        .shift_in  (8'h00),
        .data      (addr_word)
    );

    lsu_byte_shifter #(.WIDTH_BYTES(DATA_BYTES)) u_wdat (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (req_wdata),
        .shift     (state_q == TX_DATA && byte_done),
        .shift_in  (8'h00),
        .data      (wdat_word)
    );

    lsu_byte_shifter #(.WIDTH_BYTES(DATA_BYTES)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .load      (rx_clr),
        .load_data ('0),
        .shift     (rx_take),
        .shift_in  (rx_data),
        .data      (rx_word)
    );

    always_comb begin
        state_d     = state_q;
        req_ready   = (state_q == IDLE);
        accept      = req_valid && (state_q == IDLE);
        is_tx       = (state_q == TX_FLAG) || (state_q == TX_ADDR) || (state_q == TX_DATA);
        tx_start    = is_tx && !tx_wait_q;
        // tx_done only counts once the byte has been handed over and we are waiting
        byte_done   = is_tx && tx_wait_q && tx_done;
        rx_take     = (state_q == RX_DATA) && rx_valid;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == RX_DATA) && !rx_valid
                      && (tcnt_q == TO_LAST);

        case (state_q)
            TX_FLAG: tx_data = flag_q;
            TX_ADDR: tx_data = addr_word[AW-1 -: 8];
            TX_DATA: tx_data = wdat_word[DW-1 -: 8];
            default: tx_data = hold_q;
        endcase

        case (state_q)
            IDLE:    if (accept) state_d = TX_FLAG;
            TX_FLAG: if (byte_done) state_d = TX_ADDR;
            TX_ADDR: if (byte_done && bcnt_q == ADDR_LAST)
                         state_d = (op_q == OP_STORE) ? TX_DATA : RX_DATA;
            TX_DATA: if (byte_done && bcnt_q == DATA_LAST) state_d = RESP;
            RX_DATA: if ((rx_take && bcnt_q == DATA_LAST) || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rx_clr    = (state_d == RX_DATA) && (state_q != RX_DATA);
        rsp_valid = (state_q == RESP);
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_LOAD;
            flag_q    <= '0;
            tx_wait_q <= 1'b0;
            hold_q    <= '0;
            bcnt_q    <= '0;
            tcnt_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                op_q   <= req_store ? OP_STORE : OP_LOAD;
                flag_q <= req_store ? FLAG_STORE : FLAG_LOAD;
            end

            if (tx_start) begin
                tx_wait_q <= 1'b1;
                hold_q    <= tx_data;
            end else if (byte_done) begin
                tx_wait_q <= 1'b0;
            end

            if (state_d != state_q)
                bcnt_q <= '0;
            else if (byte_done || rx_take)
                bcnt_q <= bcnt_q + 1'b1;

            if (rx_clr || rx_take)
                tcnt_q <= '0;
            else if (state_q == RX_DATA)
                tcnt_q <= tcnt_q + 1'b1;

            // A final byte arriving in the timeout cycle takes priority over the timeout
            if (state_q == RX_DATA && state_d == RESP) begin
                err_q   <= !rx_take;
                rdata_q <= rx_take ? ((rx_word << 8) | DW'(rx_data)) : '0;
            end else if (state_q == TX_DATA && state_d == RESP) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_uart_bridge.sv
// Directed bench: three bridge configurations share stimulus, one selected at a time.
module tb_lsu_uart_bridge;

    logic        clk;
    logic        reset;
    logic        req_valid, req_store, tx_done, rx_valid;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  rx_data;
    int          sel;

    logic        rdy [3];
    logic        rv  [3];
    logic        er  [3];
    logic        ts  [3];
    logic [7:0]  td  [3];
    logic [15:0] rd0, rd2;
    logic [31:0] rd1;

    logic        rdy_m, rv_m, er_m, ts_m;
    logic [7:0]  td_m;
    logic [31:0] rd_m;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int n_rsp   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lsu_uart_bridge u_d0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel == 0), .req_ready(rdy[0]), .req_store(req_store),
        .req_addr(req_addr[7:0]), .req_wdata(req_wdata[15:0]),
        .rsp_valid(rv[0]), .rsp_rdata(rd0), .rsp_err(er[0]),
        .tx_start(ts[0]), .tx_data(td[0]), .tx_done(tx_done && sel == 0),
        .rx_valid(rx_valid && sel == 0), .rx_data(rx_data)
    );

    lsu_uart_bridge #(.ADDR_BYTES(2), .DATA_BYTES(4)) u_d1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel == 1), .req_ready(rdy[1]), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rd1), .rsp_err(er[1]),
        .tx_start(ts[1]), .tx_data(td[1]), .tx_done(tx_done && sel == 1),
        .rx_valid(rx_valid && sel == 1), .rx_data(rx_data)
    );

    lsu_uart_bridge #(.TIMEOUT_CYCLES(20)) u_d2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel == 2), .req_ready(rdy[2]), .req_store(req_store),
        .req_addr(req_addr[7:0]), .req_wdata(req_wdata[15:0]),
        .rsp_valid(rv[2]), .rsp_rdata(rd2), .rsp_err(er[2]),
        .tx_start(ts[2]), .tx_data(td[2]), .tx_done(tx_done && sel == 2),
        .rx_valid(rx_valid && sel == 2), .rx_data(rx_data)
    );

    always_comb begin
        rdy_m = rdy[sel];
        rv_m  = rv[sel];
        er_m  = er[sel];
        ts_m  = ts[sel];
        td_m  = td[sel];
        case (sel)
            1:       rd_m = rd1;
            2:       rd_m = {16'h0, rd2};
            default: rd_m = {16'h0, rd0};
        endcase
    end

    always @(negedge clk) begin
        if (ts_m) n_start <= n_start + 1;
        if (rv_m) n_rsp   <= n_rsp + 1;
    end

    typedef struct {
        int          sel;
        logic        store;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          n_tx;
        logic [55:0] tx;
        int          n_rx;
        logic [31:0] rx;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input logic st, input logic [15:0] a, input logic [31:0] wd);
        int k = 0;
        while (!rdy_m && k < 50) begin @(negedge clk); k++; end
        req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        chk("accepted", {31'b0, rdy_m}, 32'd0);
    endtask

    // Asserts tx_done alongside tx_start first; that must not advance the byte.
    task automatic tx_byte(input logic [7:0] exp);
        int k = 0;
        while (!ts_m && k < 50) begin @(negedge clk); k++; end
        chk("tx_start", {31'b0, ts_m}, 32'd1);
        chk("tx_data", {24'b0, td_m}, {24'b0, exp});
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("tx_start_once", {31'b0, ts_m}, 32'd0);
        chk("tx_data_hold", {24'b0, td_m}, {24'b0, exp});
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic e, input logic [31:0] rd);
        int k = 0;
        while (!rv_m && k < 100) begin @(negedge clk); k++; end
        chk("rsp_valid", {31'b0, rv_m}, 32'd1);
        chk("rsp_err", {31'b0, er_m}, {31'b0, e});
        chk("rsp_rdata", rd_m, rd);
        @(negedge clk);
        chk("rsp_pulse", {31'b0, rv_m}, 32'd0);
        chk("ready_after", {31'b0, rdy_m}, 32'd1);
    endtask

    initial begin
        logic [55:0] tsh;
        logic [31:0] rsh;
        int s0, r0, edges;

        vecs[0] = '{0, 1'b0, 16'h003C, 32'h0,        2, 56'h013C,           2, 32'hABCD,     32'hABCD};
        vecs[1] = '{0, 1'b1, 16'h0010, 32'h1234,     4, 56'h02101234,       0, 32'h0,        32'hABCD};
        vecs[2] = '{1, 1'b0, 16'hBEEF, 32'h0,        3, 56'h01BEEF,         4, 32'hDEAD0001, 32'hDEAD0001};
        vecs[3] = '{1, 1'b1, 16'h0001, 32'hCAFEF00D, 7, 56'h020001CAFEF00D, 0, 32'h0,        32'hDEAD0001};
        vecs[4] = '{0, 1'b0, 16'h00FF, 32'h0,        2, 56'h01FF,           2, 32'h0080,     32'h0080};
        vecs[5] = '{2, 1'b0, 16'h0000, 32'h0,        2, 56'h0100,           2, 32'h5AA5,     32'h5AA5};

        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_wdata = '0;
        tx_done = 1'b0; rx_valid = 1'b0; rx_data = '0; sel = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, rdy_m}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rv_m}, 32'd0);
        chk("rst_err", {31'b0, er_m}, 32'd0);
        chk("rst_tx_start", {31'b0, ts_m}, 32'd0);
        chk("rst_tx_data", {24'b0, td_m}, 32'd0);
        chk("rst_rdata", rd_m, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // rx byte while idle must be dropped
        rx_byte(8'h77);
        chk("idle_rx_ready", {31'b0, rdy_m}, 32'd1);
        chk("idle_rx_tx", {31'b0, ts_m}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            sel = vecs[v].sel;
            @(negedge clk);
            s0 = n_start;
            do_req(vecs[v].store, vecs[v].addr, vecs[v].wdata);
            for (int j = 0; j < vecs[v].n_tx; j++) begin
                tsh = vecs[v].tx >> (8 * (vecs[v].n_tx - 1 - j));
                tx_byte(tsh[7:0]);
            end
            for (int j = 0; j < vecs[v].n_rx; j++) begin
                rsh = vecs[v].rx >> (8 * (vecs[v].n_rx - 1 - j));
                rx_byte(rsh[7:0]);
            end
            wait_rsp(1'b0, vecs[v].rdata);
            chk("tx_count", n_start - s0, vecs[v].n_tx);
        end

        // req_valid held through a load: fields latched, next accept only after RESP
        sel = 0;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_addr = 16'h0055;
        @(negedge clk);
        chk("held_busy", {31'b0, rdy_m}, 32'd0);
        req_addr = 16'h0066; req_store = 1'b1; req_wdata = 32'h9876;
        tx_byte(8'h01);
        tx_byte(8'h55);
        rx_byte(8'h12);
        rx_byte(8'h34);
        wait_rsp(1'b0, 32'h1234);
        @(negedge clk);
        req_valid = 1'b0;
        tx_byte(8'h02);
        tx_byte(8'h66);
        tx_byte(8'h98);
        tx_byte(8'h76);
        wait_rsp(1'b0, 32'h1234);

        // timeout after a single rx byte
        sel = 2;
        @(negedge clk);
        do_req(1'b0, 16'h0042, 32'h0);
        tx_byte(8'h01);
        tx_byte(8'h42);
        rx_byte(8'h99);
        edges = 0;
        while (!rv_m && edges < 100) begin @(negedge clk); edges++; end
        chk("timeout_latency", edges, 32'd20);
        wait_rsp(1'b1, 32'h0);
        do_req(1'b0, 16'h0043, 32'h0);
        tx_byte(8'h01);
        tx_byte(8'h43);
        rx_byte(8'h11);
        rx_byte(8'h22);
        wait_rsp(1'b0, 32'h1122);

        // byte arriving in the timeout cycle wins
        do_req(1'b0, 16'h0044, 32'h0);
        tx_byte(8'h01);
        tx_byte(8'h44);
        rx_byte(8'h33);
        repeat (19) @(negedge clk);
        rx_byte(8'h44);
        wait_rsp(1'b0, 32'h3344);

        // reset after the address byte aborts silently
        sel = 0;
        @(negedge clk);
        do_req(1'b0, 16'h003C, 32'h0);
        tx_byte(8'h01);
        tx_byte(8'h3C);
        rx_byte(8'hAA);
        s0 = n_start;
        r0 = n_rsp;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {31'b0, rdy_m}, 32'd1);
        chk("mid_rst_rsp_valid", {31'b0, rv_m}, 32'd0);
        chk("mid_rst_tx_start", {31'b0, ts_m}, 32'd0);
        chk("mid_rst_tx_data", {24'b0, td_m}, 32'd0);
        chk("mid_rst_err", {31'b0, er_m}, 32'd0);
        chk("mid_rst_rdata", rd_m, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rx_byte(8'hBB);
        repeat (5) @(negedge clk);
        chk("mid_rst_no_rsp", n_rsp - r0, 32'd0);
        chk("mid_rst_no_tx", n_start - s0, 32'd0);
        do_req(1'b1, 16'h0021, 32'hBEEF);
        tx_byte(8'h02);
        tx_byte(8'h21);
        tx_byte(8'hBE);
        tx_byte(8'hEF);
        wait_rsp(1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_uart_bridge.md
Name: lsu_uart_bridge

Overview:
- Parametrised load/store unit that turns one core memory request into a UART byte transaction with an external memory host.
- Frame: flag byte, then the address bytes (MSB first), then the data bytes (MSB first).
- Store data is sent by the block; load data is received from the host.
- Sits between the core datapath and the UART tx/rx pair, and replaces the fixed 8-bit-address / 16-bit-data LSU.
- Adds a valid/ready request port, a one-cycle response pulse, and a receive timeout with an error flag.

Parameters:
- ADDR_BYTES, 1, address width in bytes (1..4); address is 8*ADDR_BYTES bits.
- DATA_BYTES, 2, data width in bytes (1..4); data is 8*DATA_BYTES bits.
- TIMEOUT_CYCLES, 65535, maximum clk cycles to wait for each rx byte; 0 disables the timeout.
- FLAG_LOAD, 8'h01, flag byte sent for a load.
- FLAG_STORE, 8'h02, flag byte sent for a store.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_store  in  1  1 = store, 0 = load
- req_addr  in  8*ADDR_BYTES  request address
- req_wdata  in  8*DATA_BYTES  store data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8*DATA_BYTES  load data; held until the next response
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- tx_start  out  1  one-cycle pulse: transmit tx_data
- tx_data  out  8  byte to transmit
- tx_done  in  1  UART finished the current byte
- rx_valid  in  1  one-cycle pulse: rx_data valid
- rx_data  in  8  received byte

Behaviour:
- Reset values: everything at 0 except req_ready, which is 1.
  - Outputs 0: rsp_valid, rsp_rdata, rsp_err, tx_start, tx_data.
  - Internal state: state=IDLE, byte counter 0, timeout counter 0.
  - Reset mid-transaction aborts immediately. No response is issued and no further tx_start is raised.
- Request acceptance:
  - Accepted on req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - op, addr and wdata are latched on acceptance; later changes on req_* are ignored.
- States: IDLE, TX_FLAG, TX_ADDR, TX_DATA, RX_DATA, RESP.
- Transmit handshake (each TX state, per byte):
  - Cycle 1: tx_start=1, tx_data=byte.
  - Following cycles: tx_start=0, tx_data held, waiting for tx_done.
  - tx_done in the same cycle as tx_start is ignored.
  - tx_done seen outside a wait sub-phase is ignored.
- Transitions:
  - IDLE -> TX_FLAG on acceptance. FLAG_STORE if req_store else FLAG_LOAD.
  - TX_FLAG -> TX_ADDR on tx_done.
  - TX_ADDR: sends ADDR_BYTES bytes, address MSB first. After the last tx_done, goes to TX_DATA for a store or RX_DATA for a load.
  - TX_DATA: sends DATA_BYTES bytes of wdata, MSB first. After the last tx_done -> RESP.
  - RX_DATA: each rx_valid shifts rx_data into the LSB of the load register (first byte ends up MSB). After DATA_BYTES bytes -> RESP with err=0.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready returns to 1 the following cycle.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter clears on entry to RX_DATA and on every rx_valid, and increments every other RX_DATA cycle.
  - When it reaches TIMEOUT_CYCLES -> RESP with rsp_err=1 and rsp_rdata=0.
  - rx_valid in the same cycle as the timeout wins: the byte is accepted and the counter clears.
- rx_valid outside RX_DATA is discarded; no state change.
- Store response: rsp_err=0. rsp_rdata is unchanged by a store.
- Back-to-back requests: minimum gap is 1 idle cycle (the RESP cycle).
- Byte counter width is clog2(max(ADDR_BYTES, DATA_BYTES)) + 1. It wraps only via explicit clear on each state entry.

Decomposition:
- Package lsu_pkg:
  - state enum;
  - FLAG_LOAD and FLAG_STORE default constants;
  - op encoding (OP_LOAD=0, OP_STORE=1).
- Sub-module lsu_byte_shifter, parametrised on WIDTH_BYTES, reused for the address, store and load registers:
  - parallel load;
  - MSB-first byte shift-out;
  - LSB shift-in.
- The FSM and the timeout counter stay in the top module.

Test Plan:
- Load, defaults: addr=8'h3C; host replies 8'hAB then 8'hCD.
  - tx sequence 01, 3C.
  - One rsp_valid pulse with rdata=16'hABCD, err=0.
- Store, defaults: addr=8'h10, wdata=16'h1234.
  - tx sequence 02, 10, 12, 34.
  - Exactly 4 tx_start pulses, each waiting for tx_done.
  - rsp_valid with err=0 and no rx consumed.
- Wide configuration, ADDR_BYTES=2 and DATA_BYTES=4: load addr=16'hBEEF, reply DE AD 00 01.
  - tx sequence 01, BE, EF.
  - rdata=32'hDEAD0001.
- Timeout, TIMEOUT_CYCLES=20: load; host sends only the first byte.
  - rsp_valid with err=1 and rdata=0, exactly 20 cycles after that byte.
  - The next load then succeeds.
- Reset after the address byte has been sent:
  - all outputs return to their reset values;
  - no rsp_valid pulse;
  - a fresh request starts from TX_FLAG.
- Spurious stimulus:
  - rx_valid in IDLE is ignored.
  - tx_done asserted together with tx_start does not advance the byte.
  - req_valid held high during a transaction is accepted only after RESP.
